// File: rtl/tone_correlator_if.sv
`default_nettype none
// ============================================================================
// Module      : tone_correlator_if
// Description : Sample/reference inputs and I/Q result outputs of the
//               single-bin quadrature correlator. The mag_out signal exists
//               only when TONE_CORRELATOR_MAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface tone_correlator_if #(
    parameter int DATA_W = 32,
    parameter int N      = 32,
    parameter int ACC_W  = 2 * DATA_W + $clog2(N)
);
    logic signed [DATA_W-1:0]   sample_in;
    logic signed [DATA_W-1:0]   sin_in;
    logic signed [DATA_W-1:0]   cos_in;
    logic                       sample_valid;
    logic                       clear;
    logic signed [ACC_W-1:0]    i_out;
    logic signed [ACC_W-1:0]    q_out;
    logic                       result_valid;
    logic [$clog2(N)-1:0]       sample_count;
`ifdef TONE_CORRELATOR_MAG_EN
    logic [ACC_W:0]             mag_out;
`endif

    // Source of samples (driver side)
    modport master (
        output sample_in, sin_in, cos_in, sample_valid, clear,
        input  i_out, q_out, result_valid, sample_count
`ifdef TONE_CORRELATOR_MAG_EN
        , mag_out
`endif
    );

    // Correlator side
    modport slave (
        input  sample_in, sin_in, cos_in, sample_valid, clear,
        output i_out, q_out, result_valid, sample_count
`ifdef TONE_CORRELATOR_MAG_EN
        , mag_out
`endif
    );
endinterface
`default_nettype wire

// File: rtl/tone_correlator.sv
`default_nettype none
// ============================================================================
// Module      : tone_correlator
// Description : Single-bin quadrature correlator. Multiplies each valid
//               sample by the sine/cosine references (stage 1), accumulates
//               the products over N samples (stage 2) and emits I/Q sums
//               with a one-cycle result_valid strobe.
//               Optional macro TONE_CORRELATOR_MAG_EN adds mag_out = |I|+|Q|.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_correlator #(
    parameter int DATA_W = 32,
    parameter int N      = 32,
    parameter int ACC_W  = 2 * DATA_W + $clog2(N)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    tone_correlator_if.slave     bus
);
    localparam int                c_CNT_W  = $clog2(N);
    localparam int                c_PROD_W = 2 * DATA_W;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);

    // Stage-1 registers: full-precision products plus valid/last tags
    logic signed [c_PROD_W-1:0] r_p_i_q;
    logic signed [c_PROD_W-1:0] r_p_q_q;
    logic                       r_p_valid_q;
    logic                       r_p_last_q;
    logic [c_CNT_W-1:0]         r_cnt_q;

    // Stage-2 registers: running sums and held results
    logic signed [ACC_W-1:0]    r_acc_i_q;
    logic signed [ACC_W-1:0]    r_acc_q_q;
    logic signed [ACC_W-1:0]    r_i_out_q;
    logic signed [ACC_W-1:0]    r_q_out_q;
    logic                       r_result_valid_q;

    // Operands are widened first so the product is formed at full width
    logic signed [c_PROD_W-1:0] w_prod_i;
    logic signed [c_PROD_W-1:0] w_prod_q;
    assign w_prod_i = c_PROD_W'(bus.sample_in) * c_PROD_W'(bus.sin_in);
    assign w_prod_q = c_PROD_W'(bus.sample_in) * c_PROD_W'(bus.cos_in);

    // Sign-extended stage-1 products and the window sum including them
    logic signed [ACC_W-1:0]    w_ext_i;
    logic signed [ACC_W-1:0]    w_ext_q;
    logic signed [ACC_W-1:0]    w_sum_i_d;
    logic signed [ACC_W-1:0]    w_sum_q_d;
    assign w_ext_i   = {{(ACC_W - c_PROD_W){r_p_i_q[c_PROD_W-1]}}, r_p_i_q};
    assign w_ext_q   = {{(ACC_W - c_PROD_W){r_p_q_q[c_PROD_W-1]}}, r_p_q_q};
    assign w_sum_i_d = r_acc_i_q + w_ext_i;
    assign w_sum_q_d = r_acc_q_q + w_ext_q;

`ifdef TONE_CORRELATOR_MAG_EN
    // One extra bit so |-2^(ACC_W-1)| is representable
    logic [ACC_W:0] w_wide_i;
    logic [ACC_W:0] w_wide_q;
    logic [ACC_W:0] w_abs_i;
    logic [ACC_W:0] w_abs_q;
    logic [ACC_W:0] w_mag_d;
    logic [ACC_W:0] r_mag_q;
    assign w_wide_i = {w_sum_i_d[ACC_W-1], w_sum_i_d};
    assign w_wide_q = {w_sum_q_d[ACC_W-1], w_sum_q_d};
    assign w_abs_i  = w_wide_i[ACC_W] ? (~w_wide_i + (ACC_W + 1)'(1)) : w_wide_i;
    assign w_abs_q  = w_wide_q[ACC_W] ? (~w_wide_q + (ACC_W + 1)'(1)) : w_wide_q;
    assign w_mag_d  = w_abs_i + w_abs_q;

    // Magnitude register updates alongside i_out/q_out; clear never touches it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag_q <= '0;
        end else if (!bus.clear && r_p_valid_q && r_p_last_q) begin
            r_mag_q <= w_mag_d;
        end
    end

    assign bus.mag_out = r_mag_q;
`endif

    // Multiply, accumulate and window-completion pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_i_q          <= '0;
            r_p_q_q          <= '0;
            r_p_valid_q      <= 1'b0;
            r_p_last_q       <= 1'b0;
            r_cnt_q          <= '0;
            r_acc_i_q        <= '0;
            r_acc_q_q        <= '0;
            r_i_out_q        <= '0;
            r_q_out_q        <= '0;
            r_result_valid_q <= 1'b0;
        end else begin
            r_result_valid_q <= 1'b0;
            if (bus.clear) begin
                // Restart the window; a pending completion is dropped too
                r_p_valid_q <= 1'b0;
                r_p_last_q  <= 1'b0;
                r_cnt_q     <= '0;
                r_acc_i_q   <= '0;
                r_acc_q_q   <= '0;
            end else begin
                r_p_valid_q <= bus.sample_valid;
                if (bus.sample_valid) begin
                    r_p_i_q    <= w_prod_i;
                    r_p_q_q    <= w_prod_q;
                    r_p_last_q <= (r_cnt_q == c_LAST);
                    // N is a power of two, so the natural wrap gives N-1 -> 0
                    r_cnt_q    <= r_cnt_q + c_CNT_W'(1);
                end else begin
                    r_p_last_q <= 1'b0;
                end

                if (r_p_valid_q) begin
                    if (r_p_last_q) begin
                        // Last product goes straight into the result so the
                        // next window's first product is never dropped
                        r_i_out_q        <= w_sum_i_d;
                        r_q_out_q        <= w_sum_q_d;
                        r_result_valid_q <= 1'b1;
                        r_acc_i_q        <= '0;
                        r_acc_q_q        <= '0;
                    end else begin
                        r_acc_i_q <= w_sum_i_d;
                        r_acc_q_q <= w_sum_q_d;
                    end
                end
            end
        end
    end

    assign bus.i_out        = r_i_out_q;
    assign bus.q_out        = r_q_out_q;
    assign bus.result_valid = r_result_valid_q;
    assign bus.sample_count = r_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_tone_correlator.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_correlator
// Description : Self-checking bench for tone_correlator. A window-level
//               reference model (per-window sums, one pending result two
//               edges after the N-th sample) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_correlator;
    localparam int DATA_W = 32;
    localparam int N      = 32;
    localparam int ACC_W  = 2 * DATA_W + $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tone_correlator_if #(.DATA_W(DATA_W), .N(N), .ACC_W(ACC_W)) bus ();

    tone_correlator #(.DATA_W(DATA_W), .N(N), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic signed [ACC_W-1:0] m_sum_i, m_sum_q;
    int                      m_cnt;
    bit                      m_pend;
    logic signed [ACC_W-1:0] m_pend_i, m_pend_q;
    logic signed [ACC_W-1:0] exp_i, exp_q;
    logic [ACC_W:0]          exp_mag;
    bit                      exp_rv;

    task automatic chk(input string tag, input logic [ACC_W:0] obs, input logic [ACC_W:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic signed [ACC_W-1:0] mul(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
        logic signed [ACC_W-1:0] x;
        logic signed [ACC_W-1:0] y;
        x = a;
        y = b;
        return x * y;
    endfunction

    function automatic logic [ACC_W:0] absv(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] x;
        x = v;
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic signed [ACC_W-1:0] sx(input longint v);
        logic signed [ACC_W-1:0] r;
        r = v;
        return r;
    endfunction

    task automatic model_reset();
        m_sum_i = '0; m_sum_q = '0; m_cnt = 0; m_pend = 0;
        m_pend_i = '0; m_pend_q = '0;
        exp_i = '0; exp_q = '0; exp_mag = '0; exp_rv = 0;
    endtask

    // Effect of one clock edge on the window-level model
    task automatic model_edge(input logic signed [DATA_W-1:0] s, si, co, input bit v, clr);
        exp_rv = 0;
        if (clr) begin
            m_pend = 0; m_sum_i = '0; m_sum_q = '0; m_cnt = 0;
        end else begin
            if (m_pend) begin
                exp_i   = m_pend_i;
                exp_q   = m_pend_q;
                exp_mag = absv(m_pend_i) + absv(m_pend_q);
                exp_rv  = 1;
                m_pend  = 0;
            end
            if (v) begin
                m_sum_i += mul(s, si);
                m_sum_q += mul(s, co);
                m_cnt++;
                if (m_cnt == N) begin
                    m_pend = 1; m_pend_i = m_sum_i; m_pend_q = m_sum_q;
                    m_sum_i = '0; m_sum_q = '0; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("result_valid", {{ACC_W{1'b0}}, bus.result_valid}, {{ACC_W{1'b0}}, exp_rv});
        chk("sample_count", (ACC_W + 1)'(bus.sample_count), (ACC_W + 1)'(m_cnt));
        chk("i_out", bus.i_out, exp_i);
        chk("q_out", bus.q_out, exp_q);
`ifdef TONE_CORRELATOR_MAG_EN
        chk("mag_out", bus.mag_out, exp_mag);
`endif
    endtask

    // Present one cycle of stimulus, advance one edge, then check
    task automatic step(input logic signed [DATA_W-1:0] s, si, co, input bit v, clr);
        bus.sample_in = s; bus.sin_in = si; bus.cos_in = co;
        bus.sample_valid = v; bus.clear = clr;
        @(posedge clk);
        model_edge(s, si, co, v, clr);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step($urandom, $urandom, $urandom, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once
    task automatic async_reset();
        @(negedge clk);
        bus.sample_valid = 1'b0; bus.clear = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_rv", {{ACC_W{1'b0}}, bus.result_valid}, '0);
        chk("rst_cnt", (ACC_W + 1)'(bus.sample_count), '0);
        chk("rst_i", bus.i_out, '0);
        chk("rst_q", bus.q_out, '0);
`ifdef TONE_CORRELATOR_MAG_EN
        chk("rst_mag", bus.mag_out, '0);
`endif
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic signed [DATA_W-1:0] sin_tab [N];
    logic signed [DATA_W-1:0] cos_tab [N];
    logic signed [DATA_W-1:0] minv;
    logic signed [ACC_W-1:0]  p67, ssq;
    logic [ACC_W:0]           qabs;
    logic [ACC_W:0]           qlim;

    initial begin
        bus.sample_in = '0; bus.sin_in = '0; bus.cos_in = '0;
        bus.sample_valid = 1'b0; bus.clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        async_reset();

        // Constant window
        for (int k = 0; k < N; k++) step(1000, 3, -2, 1'b1, 1'b0);
        idle(3);
        chk("const_i", bus.i_out, sx(96000));
        chk("const_q", bus.q_out, sx(-64000));
`ifdef TONE_CORRELATOR_MAG_EN
        chk("const_mag", bus.mag_out, (ACC_W + 1)'(160000));
`endif

        // Back-to-back windows, second one with random gaps
        for (int k = 0; k < N; k++) step(1, 1, 0, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) begin
            step(-5, 2, 7, 1'b1, 1'b0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        chk("gap_i", bus.i_out, sx(-320));
        chk("gap_q", bus.q_out, sx(-1120));

        // Extremes: 32 * (-2^31)^2 = 2^67
        minv = {1'b1, {(DATA_W - 1){1'b0}}};
        for (int k = 0; k < N; k++) step(minv, minv, minv, 1'b1, 1'b0);
        idle(3);
        p67 = sx(1);
        p67 = p67 << 67;
        chk("ext_i", bus.i_out, p67);
        chk("ext_q", bus.q_out, p67);

        // Clear mid-window, asserted together with a valid sample
        for (int k = 0; k < 10; k++) step(7, 7, 7, 1'b1, 1'b0);
        step(7, 7, 7, 1'b1, 1'b1);
        for (int k = 0; k < N; k++) step(1, 1, 1, 1'b1, 1'b0);
        idle(3);
        chk("clr_i", bus.i_out, sx(32));
        chk("clr_q", bus.q_out, sx(32));

        // Clear landing on the cycle before a scheduled pulse
        for (int k = 0; k < N; k++) step(2, 2, 2, 1'b1, 1'b0);
        step(0, 0, 0, 1'b0, 1'b1);
        idle(3);
        chk("cancel_i", bus.i_out, sx(32));

        // Randomized traffic with gaps and occasional clears
        for (int k = 0; k < 600; k++) begin
            step($urandom, $urandom, $urandom, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 149) == 0));
        end
        idle(3);

        // Reset mid-window: partial window discarded
        for (int k = 0; k < 13; k++) step($urandom, $urandom, $urandom, 1'b1, 1'b0);
        async_reset();
        for (int k = 0; k < N; k++) step(3, 1, -1, 1'b1, 1'b0);
        idle(3);
        chk("rstmid_i", bus.i_out, sx(96));

        // In-phase tone from a real sine/cosine LUT
        ssq = '0;
        for (int k = 0; k < N; k++) begin
            sin_tab[k] = $rtoi($floor(1073741824.0 * $sin(2.0 * 3.14159265358979 * k / N) + 0.5));
            cos_tab[k] = $rtoi($floor(1073741824.0 * $cos(2.0 * 3.14159265358979 * k / N) + 0.5));
            ssq += mul(sin_tab[k], sin_tab[k]);
        end
        step(0, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < N; k++) step(sin_tab[k], sin_tab[k], cos_tab[k], 1'b1, 1'b0);
        idle(3);
        chk("lut_i", bus.i_out, ssq);
        chk("lut_ipos", {{ACC_W{1'b0}}, (bus.i_out > 0)}, (ACC_W + 1)'(1));
        qabs = absv(bus.q_out);
        qlim = (ACC_W + 1)'(N) << DATA_W;
        chk("lut_qsmall", {{ACC_W{1'b0}}, (qabs <= qlim)}, (ACC_W + 1)'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #2000000;
        n_bad++;
        $display("FAIL timeout reached at %0t", $time);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
